// File: rtl/spram_rd_arbiter.sv
// spram_rd_arbiter
// Two-requester round-robin read arbiter in front of a shared single-port RAM.
// A grant issues the RAM read in the same cycle, and the response follows one
// cycle later. A write that hits the granted address in the grant cycle is
// forwarded into that response, because the RAM returns the pre-write contents.
// Each port's rdata holds its last response until the next one arrives.
module spram_rd_arbiter #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    output logic                  gnt1,
    output logic                  rvalid1,
    output logic [DATA_WIDTH-1:0] rdata1,
    input  logic                  req2,
    input  logic [ADDR_WIDTH-1:0] addr2,
    output logic                  gnt2,
    output logic                  rvalid2,
    output logic [DATA_WIDTH-1:0] rdata2,
    input  logic                  write_en,
    input  logic [ADDR_WIDTH-1:0] write_addr,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic                  mem_wr_en,
    output logic [ADDR_WIDTH-1:0] mem_wr_ptr,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_rd_ptr,
    input  logic [DATA_WIDTH-1:0] mem_rd_data
);

    // last2_r high means requester 2 held the most recent grant
    logic                  last2_r;
    logic                  gnt1_s;
    logic                  gnt2_s;
    logic                  rvalid1_r;
    logic                  rvalid2_r;
    logic                  fwd_hit_r;
    logic [DATA_WIDTH-1:0] fwd_data_r;
    logic [DATA_WIDTH-1:0] hold1_r;
    logic [DATA_WIDTH-1:0] hold2_r;
    logic [DATA_WIDTH-1:0] resp_data_s;

    // True when an active write targets the address being read this cycle
    function automatic logic fwd_match(input logic                  wr_active,
                                       input logic [ADDR_WIDTH-1:0] wr_addr,
                                       input logic [ADDR_WIDTH-1:0] rd_addr);
        return wr_active && (wr_addr == rd_addr);
    endfunction

    // Round-robin grant: a lone request wins at once, contention goes to the other side
    always_comb begin
        gnt1_s = 1'b0;
        gnt2_s = 1'b0;
        if (rst) begin
            gnt1_s = 1'b0;
            gnt2_s = 1'b0;
        end else if (req1 && req2) begin
            gnt1_s = last2_r;
            gnt2_s = ~last2_r;
        end else begin
            gnt1_s = req1;
            gnt2_s = req2;
        end
    end

    // Drive the RAM read port from the winner and pass the writer straight through
    always_comb begin
        gnt1        = gnt1_s;
        gnt2        = gnt2_s;
        mem_rd_en   = gnt1_s | gnt2_s;
        mem_rd_ptr  = gnt2_s ? addr2 : addr1;
        mem_wr_en   = write_en;
        mem_wr_ptr  = write_addr;
        mem_wr_data = write_data;
    end

    // Remember the last winner; it only moves on a grant cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            last2_r <= 1'b1;
        end else if (gnt1_s || gnt2_s) begin
            last2_r <= gnt2_s;
        end else begin
            last2_r <= last2_r;
        end
    end

    // Pipeline the grant into next-cycle valids and capture any same-cycle write hit
    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid1_r  <= 1'b0;
            rvalid2_r  <= 1'b0;
            fwd_hit_r  <= 1'b0;
            fwd_data_r <= {DATA_WIDTH{1'b0}};
        end else begin
            rvalid1_r  <= gnt1_s;
            rvalid2_r  <= gnt2_s;
            fwd_hit_r  <= fwd_match(write_en && (gnt1_s || gnt2_s), write_addr, mem_rd_ptr);
            fwd_data_r <= write_data;
        end
    end

    // Keep each port's last response so rdata holds between valids
    always_ff @(posedge clk) begin
        if (rst) begin
            hold1_r <= {DATA_WIDTH{1'b0}};
            hold2_r <= {DATA_WIDTH{1'b0}};
        end else begin
            if (rvalid1_r) begin
                hold1_r <= resp_data_s;
            end
            if (rvalid2_r) begin
                hold2_r <= resp_data_s;
            end
        end
    end

    // Select the response data and present it, forcing zeros while in reset
    always_comb begin
        resp_data_s = fwd_hit_r ? fwd_data_r : mem_rd_data;
        if (rst) begin
            rvalid1 = 1'b0;
            rvalid2 = 1'b0;
            rdata1  = {DATA_WIDTH{1'b0}};
            rdata2  = {DATA_WIDTH{1'b0}};
        end else begin
            rvalid1 = rvalid1_r;
            rvalid2 = rvalid2_r;
            rdata1  = rvalid1_r ? resp_data_s : hold1_r;
            rdata2  = rvalid2_r ? resp_data_s : hold2_r;
        end
    end

endmodule

// File: doc/spram_rd_arbiter.md
SPRAM_RD_ARBITER -- requirements
Module: spram_rd_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 6, address width of the shared single-port RAM.
REQ-002 Parameter DATA_WIDTH, default 64, data width of the shared RAM.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 req1  input  1  requester 1 read request; held high until gnt1 is seen.
REQ-006 addr1  input  ADDR_WIDTH  requester 1 read address; stable while req1 is high and gnt1 is low.
REQ-007 gnt1  output  1  requester 1 granted this cycle (combinational).
REQ-008 rvalid1  output  1  requester 1 read data valid (registered).
REQ-009 rdata1  output  DATA_WIDTH  requester 1 read data.
REQ-010 req2, addr2, gnt2, rvalid2, rdata2 SHALL mirror REQ-005..REQ-009 for requester 2.
REQ-011 write_en  input  1  write strobe from the single writer.
REQ-012 write_addr  input  ADDR_WIDTH  write address.
REQ-013 write_data  input  DATA_WIDTH  write data.
REQ-014 mem_wr_en, mem_wr_ptr, mem_wr_data  output  1/ADDR_WIDTH/DATA_WIDTH  driven to the RAM write port as direct combinational copies of write_en, write_addr, write_data.
REQ-015 mem_rd_en  output  1  RAM read enable.
REQ-016 mem_rd_ptr  output  ADDR_WIDTH  RAM read address.
REQ-017 mem_rd_data  input  DATA_WIDTH  RAM read data, valid the cycle after mem_rd_en.

Function
REQ-018 Arbitration SHALL grant at most one requester per cycle: gnt1 and gnt2 are never high together.
REQ-019 With exactly one request high, that requester SHALL be granted in the same cycle.
REQ-020 With both requests high, the grant SHALL go to the requester not granted most recently (round-robin).
REQ-021 The last-grant pointer SHALL update only on a grant cycle.
REQ-022 mem_rd_en SHALL equal gnt1|gnt2; mem_rd_ptr SHALL be the granted requester's address, else addr1.
REQ-023 On a grant, rvalid of the granted port SHALL be high exactly one cycle later, for exactly one cycle, and the other port's rvalid SHALL stay low.
REQ-024 rdataN SHALL carry mem_rd_data during the rvalidN cycle, then hold that value until the next rvalidN.
REQ-025 Write forwarding: when write_en is high and write_addr equals the granted address in the grant cycle, the response SHALL carry write_data from that cycle instead of mem_rd_data.
REQ-026 A write in the cycle after the grant SHALL NOT affect that response.
REQ-027 Back-to-back grants SHALL be allowed every cycle: throughput is one read per cycle, latency one cycle.
REQ-028 A requester keeping its request high after its grant SHALL be treated as a new request.

Reset
REQ-029 While rst is high: gnt1, gnt2, mem_rd_en, rvalid1, rvalid2 SHALL be 0; rdata1 and rdata2 SHALL be 0; last-grant pointer SHALL select requester 2 so requester 1 wins the first contention.
REQ-030 A grant issued in the cycle rst asserts SHALL produce no rvalid; the first cycle after rst deasserts SHALL arbitrate normally.
REQ-031 mem_wr_* pass-through SHALL NOT be gated by rst.

Verification
REQ-032 After reset, req1=req2=1, addr1=3, addr2=5 for 4 cycles -> grants 1,2,1,2; rvalid1/rvalid2 alternate one cycle later with RAM contents of 3,5,3,5.
REQ-033 Only req2=1 with addr2=7 for 3 cycles -> gnt2 every cycle; rvalid2 high for 3 consecutive cycles; rvalid1 low throughout.
REQ-034 Grant to addr1=9 with write_en=1, write_addr=9, write_data=0xA5 in the same cycle -> rdata1=0xA5 with rvalid1 next cycle; with write_addr=10 instead, old RAM data is returned.
REQ-035 Grant to requester 1, then rst=1 in the next cycle -> rvalid1=0, rdata1=0; after rst release both requesting -> requester 1 granted first.
REQ-036 Single response then idle for 5 cycles -> rdata1 holds the returned value; rvalid1 high for exactly one cycle.
